// File: rtl/eth_frame_match_report.sv
// Samples per-script MATCHED bits at the end of each frame and queues one
// {timestamp, mask, length} event per good matching frame in a FWFT FIFO.
module eth_frame_match_report #(
  parameter int C_NUM_SCRIPTS = 4,
  parameter int C_FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [63:0]                  current_time,
  input  logic [7:0]                   s_axis_tdata,
  input  logic [17*C_NUM_SCRIPTS+2:0]  s_axis_tuser,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         m_evt_valid,
  input  logic                         m_evt_ready,
  output logic [63:0]                  m_evt_time,
  output logic [C_NUM_SCRIPTS-1:0]     m_evt_match,
  output logic [15:0]                  m_evt_length,
  output logic [31:0]                  cnt_frames,
  output logic [31:0]                  cnt_bad,
  output logic [31:0]                  cnt_overflow
);
  // state    | meaning
  // IDLE     | between frames; next valid beat is beat 0
  // IN_FRAME | beat 0 seen, waiting for tlast
  typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int EW = 64 + C_NUM_SCRIPTS + 16;

  state_t                 state_q, state_d;
  logic [63:0]            ts_q, ts_d;
  logic [15:0]            len_q, len_d;
  logic [C_NUM_SCRIPTS-1:0] mask;
  logic                   eof, bad;
  logic                   evt_pend_q;
  logic [EW-1:0]          evt_data_q;
  logic [EW-1:0]          mem_q [C_FIFO_DEPTH];
  logic [AW:0]            wr_q, rd_q;
  logic                   full, empty, push, pop;
  logic [EW-1:0]          head;
  logic                   unused_bits;

  assign unused_bits = ^{s_axis_tdata, s_axis_tuser};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s_axis_tvalid) state_d = s_axis_tlast ? ST_IDLE : ST_IN_FRAME;
  end

  // Timestamp/length as they stand including the current beat
  always_comb begin
    ts_d  = ts_q;
    len_d = len_q;
    if (state_q == ST_IDLE) begin
      ts_d  = current_time;
      len_d = 16'd1;
    end else if (len_q != 16'hFFFF) begin
      len_d = len_q + 16'd1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < C_NUM_SCRIPTS; i++) mask[i] = s_axis_tuser[17*i+3];
  end

  assign eof   = s_axis_tvalid & s_axis_tlast;
  assign bad   = s_axis_tuser[0] | (s_axis_tuser[2] & s_axis_tuser[1]);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign pop   = !empty && m_evt_ready;
  assign push  = evt_pend_q && (!full || pop);
  assign head  = mem_q[rd_q[AW-1:0]];

  assign m_evt_valid  = !empty;
  assign m_evt_time   = m_evt_valid ? head[EW-1 -: 64] : 64'd0;
  assign m_evt_match  = m_evt_valid ? head[16 +: C_NUM_SCRIPTS] : '0;
  assign m_evt_length = m_evt_valid ? head[15:0] : 16'd0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q         <= '0;
      len_q        <= '0;
      evt_pend_q   <= 1'b0;
      evt_data_q   <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_frames   <= '0;
      cnt_bad      <= '0;
      cnt_overflow <= '0;
    end else begin
      if (s_axis_tvalid) begin
        ts_q  <= ts_d;
        len_q <= len_d;
      end
      evt_pend_q <= eof && !bad && (mask != '0);
      if (eof) begin
        evt_data_q <= {ts_d, mask, len_d};
        cnt_frames <= sat_inc(cnt_frames);
        if (bad) cnt_bad <= sat_inc(cnt_bad);
      end
      if (evt_pend_q && !push) cnt_overflow <= sat_inc(cnt_overflow);
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset; the output mux hides stale entries
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= evt_data_q;
  end

endmodule
